dmem_arbiter: RTL and testbench

- Two-requester controller for the 64-entry x 64-bit data memory: arbitrates requester 0 and requester 1 with round-robin priority, and sequences the memory's write enable (datamem_ena) and read enable (memwb_ena).
- Supports full-word and byte-masked stores. Byte-masked stores use a read-modify-write sequence.
- Returns a one-cycle response carrying read data or an error.
- Sits between the pipeline MEM stage / debug-DMA port and datamem.

---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_arbiter_rr_arb2.sv | 32 +++
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared constants, state encoding and mask helper for the data-memory arbiter
package dmem_arbiter_pkg;

    localparam int DEF_ADDR_LSB = 3;
    localparam int DEF_IDX_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_ERR    = 3'd4,
        ST_RESP   = 3'd5
    } darb_state_t;

    // Widen an 8-bit byte enable into a 64-bit bit mask.
    function automatic logic [63:0] expand_mask(input logic [7:0] mask);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{mask[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-input round-robin picker with pointer register
import dmem_arbiter_pkg::*;

module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt
);

    // r_ptr = 0 favours requester 0 on a tie, 1 favours requester 1.
    logic r_ptr;

    // Pick the lone requester, or the pointer's choice when both ask.
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_ptr ? 2'b10 : 2'b01;
        end
    end

    // After each acceptance, hand priority to the requester that did not win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_update) begin
            r_ptr <= o_gnt[0];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin controller for the 64x64 data memory
import dmem_arbiter_pkg::*;

module dmem_arbiter #(
    parameter int ADDR_LSB = DEF_ADDR_LSB,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [63:0] m0_addr,
    input  logic [63:0] m0_wdata,
    input  logic [7:0]  m0_wmask,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [63:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [63:0] m1_addr,
    input  logic [63:0] m1_wdata,
    input  logic [7:0]  m1_wmask,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [63:0] m1_rdata,
    output logic        m1_err,
    output logic        datamem_ena,
    output logic        memwb_ena,
    output logic [63:0] mem_r_addr,
    output logic [63:0] mem_w_addr,
    output logic [63:0] mem_w_data,
    input  logic [63:0] mem_r_data
);

    darb_state_t      r_state;
    darb_state_t      w_next;
    logic             r_owner;
    logic             r_we;
    logic [IDX_W-1:0] r_idx;
    logic [63:0]      r_wdata;
    logic [7:0]       r_wmask;
    logic             r_err;
    logic [63:0]      r_rdata;
    logic [1:0]       r_gnt;

    logic [1:0]       w_pick;
    logic             w_accept;
    logic             w_sel_m1;
    logic             w_we;
    logic [63:0]      w_addr;
    logic [63:0]      w_wdata;
    logic [7:0]       w_wmask;
    logic             w_oor;
    logic [63:0]      w_idx_ext;
    logic             w_resp;

    rr_arb2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_req    ({m1_req, m0_req}),
        .i_update (w_accept),
        .o_gnt    (w_pick)
    );

    assign w_accept  = (r_state == ST_IDLE) && (m0_req || m1_req);
    assign w_sel_m1  = w_pick[1];
    assign w_we      = w_sel_m1 ? m1_we    : m0_we;
    assign w_addr    = w_sel_m1 ? m1_addr  : m0_addr;
    assign w_wdata   = w_sel_m1 ? m1_wdata : m0_wdata;
    assign w_wmask   = w_sel_m1 ? m1_wmask : m0_wmask;
    assign w_oor     = |w_addr[63:ADDR_LSB+IDX_W];
    assign w_idx_ext = {{(64-IDX_W){1'b0}}, r_idx};
    assign w_resp    = (r_state == ST_RESP);

    // State register; an asserted reset drops any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection and memory-side strobes, decoded from the current state.
    always_comb begin
        w_next      = r_state;
        memwb_ena   = 1'b0;
        datamem_ena = 1'b0;
        mem_r_addr  = 64'd0;
        mem_w_addr  = 64'd0;
        mem_w_data  = 64'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_oor)                 w_next = ST_ERR;
                    else if (!w_we)            w_next = ST_READ;
                    else if (w_wmask == 8'hFF) w_next = ST_WRITE;
                    else if (w_wmask == 8'h00) w_next = ST_RESP;
                    else                       w_next = ST_RMW_RD;
                end
            end
            ST_READ: begin
                memwb_ena  = 1'b1;
                mem_r_addr = w_idx_ext;
                w_next     = ST_RESP;
            end
            ST_RMW_RD: begin
                memwb_ena  = 1'b1;
                mem_r_addr = w_idx_ext;
                w_next     = ST_WRITE;
            end
            ST_WRITE: begin
                datamem_ena = 1'b1;
                mem_w_addr  = w_idx_ext;
                mem_w_data  = r_wdata;
                w_next      = ST_RESP;
            end
            ST_ERR:  w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Latch the winning request, then capture read data or the merged store word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 64'd0;
            r_wmask <= 8'd0;
            r_err   <= 1'b0;
            r_rdata <= 64'd0;
            r_gnt   <= 2'b00;
        end else begin
            r_gnt <= w_accept ? w_pick : 2'b00;
            if (w_accept) begin
                r_owner <= w_sel_m1;
                r_we    <= w_we;
                r_idx   <= w_addr[ADDR_LSB+IDX_W-1:ADDR_LSB];
                r_wdata <= w_wdata;
                r_wmask <= w_wmask;
                r_err   <= w_oor;
                r_rdata <= 64'd0;
            end else if (r_state == ST_READ) begin
                r_rdata <= mem_r_data;
            end else if (r_state == ST_RMW_RD) begin
                r_wdata <= (mem_r_data & ~expand_mask(r_wmask)) | (r_wdata & expand_mask(r_wmask));
            end
        end
    end

    assign m0_gnt    = r_gnt[0];
    assign m1_gnt    = r_gnt[1];
    assign m0_rvalid = w_resp && !r_owner;
    assign m1_rvalid = w_resp && r_owner;
    assign m0_rdata  = (m0_rvalid && !r_we) ? r_rdata : 64'd0;
    assign m1_rdata  = (m1_rvalid && !r_we) ? r_rdata : 64'd0;
    assign m0_err    = m0_rvalid && r_err;
    assign m1_err    = m1_rvalid && r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural memory model
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [63:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [7:0]  m0_wmask = 0, m1_wmask = 0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [63:0] m0_rdata, m1_rdata;
    logic        datamem_ena, memwb_ena;
    logic [63:0] mem_r_addr, mem_w_addr, mem_w_data, mem_r_data;

    logic [63:0] mem [64];
    logic [63:0] ref_mem [64];
    logic        mem_init = 1'b1;
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] last_rdata;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .datamem_ena(datamem_ena), .memwb_ena(memwb_ena),
        .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_r_data(mem_r_data)
    );

    always #5 clk = ~clk;

    assign mem_r_data = mem[mem_r_addr[5:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 64'd0;
        end else if (datamem_ena) begin
            mem[mem_w_addr[5:0]] <= mem_w_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int who, input logic req, input logic we,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [7:0] wm);
        if (who == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_wmask = wm;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_wmask = wm;
        end
    endtask

    function automatic logic gnt_of(input int who);
        return (who == 0) ? m0_gnt : m1_gnt;
    endfunction

    function automatic logic rv_of(input int who);
        return (who == 0) ? m0_rvalid : m1_rvalid;
    endfunction

    // One request from one requester: model predicts result, latency and memory effect.
    task automatic do_op(input int who, input logic we, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [7:0] wm);
        int          idx;
        logic        oor;
        int          exp_lat;
        logic [63:0] exp_rd;
        logic [63:0] bm;
        logic [63:0] rd;
        logic        er;
        bit          got;
        bit          saw_mem;
        idx = int'(addr[8:3]);
        oor = (addr[63:9] != 0);
        exp_rd = 64'd0;
        for (int i = 0; i < 8; i++) bm[8*i +: 8] = wm[i] ? 8'hFF : 8'h00;
        if (oor) exp_lat = 2;
        else if (!we) begin exp_lat = 2; exp_rd = ref_mem[idx]; end
        else if (wm == 8'hFF) begin exp_lat = 2; ref_mem[idx] = wd; end
        else if (wm == 8'h00) exp_lat = 1;
        else begin exp_lat = 3; ref_mem[idx] = (ref_mem[idx] & ~bm) | (wd & bm); end

        drive(who, 1'b1, we, addr, wd, wm);
        got = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (gnt_of(who)) begin got = 1; break; end
        end
        n_vec++;
        if (!got) begin n_err++; $display("FAIL gnt_timeout m%0d: no grant within 8 cycles, required 1", who); end
        n_vec++;
        if (gnt_of(1 - who) !== 1'b0) begin
            n_err++; $display("FAIL gnt_other m%0d: other gnt=%0b required 0", who, gnt_of(1 - who));
        end
        drive(who, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);

        got = 0; saw_mem = 0;
        for (int lat = 1; lat <= 6; lat++) begin
            if (lat > 1) step();
            saw_mem = saw_mem | memwb_ena | datamem_ena;
            if (memwb_ena) begin
                n_vec++;
                if (mem_r_addr !== 64'(idx)) begin
                    n_err++; $display("FAIL r_addr: got %0d required %0d", mem_r_addr, idx);
                end
            end
            if (datamem_ena) begin
                n_vec++;
                if (mem_w_addr !== 64'(idx)) begin
                    n_err++; $display("FAIL w_addr: got %0d required %0d", mem_w_addr, idx);
                end
            end
            if (rv_of(1 - who)) begin
                n_vec++; n_err++; $display("FAIL rvalid_other m%0d: non-owner rvalid=1 required 0", 1 - who);
            end
            if (rv_of(who)) begin
                got = 1;
                rd = (who == 0) ? m0_rdata : m1_rdata;
                er = (who == 0) ? m0_err : m1_err;
                last_rdata = rd;
                n_vec++;
                if (lat != exp_lat) begin
                    n_err++; $display("FAIL latency m%0d: got T+%0d required T+%0d", who, lat + 0, exp_lat);
                end
                n_vec++;
                if (rd !== exp_rd) begin
                    n_err++; $display("FAIL rdata m%0d idx %0d: got %h required %h", who, idx, rd, exp_rd);
                end
                n_vec++;
                if (er !== oor) begin
                    n_err++; $display("FAIL err m%0d: got %0b required %0b", who, er, oor);
                end
                break;
            end
        end
        if (!got) begin n_vec++; n_err++; $display("FAIL rvalid_timeout m%0d: no response, required one", who); end
        if (oor) begin
            n_vec++;
            if (saw_mem) begin n_err++; $display("FAIL err_mem_access: enable seen=1 required 0"); end
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        mem_init = 1'b0;
        n_vec++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, datamem_ena, memwb_ena} !== 8'd0) begin
            n_err++; $display("FAIL reset_ctrl: got %b required 0", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, datamem_ena, memwb_ena});
        end
        n_vec++;
        if ((m0_rdata | m1_rdata | mem_r_addr | mem_w_addr | mem_w_data) !== 64'd0) begin
            n_err++; $display("FAIL reset_data: got nonzero data/address outputs, required 0");
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        do_op(0, 1'b1, 64'h18, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        do_op(1, 1'b0, 64'h18, 64'd0, 8'h00);
        n_vec++;
        if (last_rdata !== 64'hDEADBEEF_CAFEF00D) begin
            n_err++; $display("FAIL load_after_store: got %h required deadbeefcafef00d", last_rdata);
        end
        do_op(0, 1'b1, 64'h18, 64'h11223344_55667788, 8'h0F);
        do_op(0, 1'b0, 64'h1C, 64'd0, 8'h00);
        n_vec++;
        if (last_rdata !== 64'hDEADBEEF_55667788) begin
            n_err++; $display("FAIL masked_merge: got %h required deadbeef55667788", last_rdata);
        end
        do_op(1, 1'b0, 64'h200, 64'd0, 8'h00);
        do_op(1, 1'b1, 64'h30, 64'h0123_4567_89AB_CDEF, 8'h00);
        do_op(1, 1'b1, 64'h28, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
    endtask

    // Both loads held from reset: grants alternate from m0 and responses follow the owner.
    task automatic test_round_robin();
        int grants[$];
        int last_g;
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 64'h18, 64'd0, 8'd0);
        drive(1, 1'b1, 1'b0, 64'h28, 64'd0, 8'd0);
        step();
        rst = 1'b0;
        last_g = -1;
        for (int c = 0; c < 13; c++) begin
            step();
            if (m0_gnt && m1_gnt) begin n_vec++; n_err++; $display("FAIL rr_double_gnt: both gnt=1 required one"); end
            if (m0_gnt) begin grants.push_back(0); last_g = 0; end
            if (m1_gnt) begin grants.push_back(1); last_g = 1; end
            if (m0_rvalid || m1_rvalid) begin
                n_vec++;
                if ((m0_rvalid ? 0 : 1) != last_g || (m0_rvalid && m1_rvalid)) begin
                    n_err++; $display("FAIL rr_resp_owner: rvalid m0=%0b m1=%0b required owner m%0d", m0_rvalid, m1_rvalid, last_g);
                end
                n_vec++;
                if ((m0_rvalid ? m0_rdata : m1_rdata) !== (m0_rvalid ? ref_mem[3] : ref_mem[5])) begin
                    n_err++; $display("FAIL rr_rdata: got %h", m0_rvalid ? m0_rdata : m1_rdata);
                end
            end
        end
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        n_vec++;
        if (grants.size() < 4) begin
            n_err++; $display("FAIL rr_count: got %0d grants required 4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (grants[i] != (i % 2)) begin
                    n_err++; $display("FAIL rr_order[%0d]: got m%0d required m%0d", i, grants[i], i % 2);
                end
            end
        end
        for (int c = 0; c < 4; c++) step();
    endtask

    task automatic test_reset_mid_write();
        bit got;
        drive(0, 1'b1, 1'b1, 64'h28, 64'h55, 8'hFF);
        got = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (m0_gnt) begin got = 1; break; end
        end
        n_vec++;
        if (!got || datamem_ena !== 1'b1 || mem_w_addr !== 64'd5) begin
            n_err++; $display("FAIL midwr_setup: gnt=%0b ena=%0b addr=%0d required 1 1 5", got, datamem_ena, mem_w_addr);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (datamem_ena !== 1'b0 || m0_gnt !== 1'b0) begin
            n_err++; $display("FAIL midwr_async: datamem_ena=%0b gnt=%0b required 0 0", datamem_ena, m0_gnt);
        end
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        step(); step();
        n_vec++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            n_err++; $display("FAIL midwr_rvalid: got %0b%0b required 00", m0_rvalid, m1_rvalid);
        end
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 64'h28, 64'd0, 8'd0);
        drive(1, 1'b1, 1'b0, 64'h30, 64'd0, 8'd0);
        step();
        n_vec++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            n_err++; $display("FAIL midwr_prio: gnt m0=%0b m1=%0b required 1 0", m0_gnt, m1_gnt);
        end
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        step();
        n_vec++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== ref_mem[5]) begin
            n_err++; $display("FAIL midwr_unchanged: rvalid=%0b rdata=%h required 1 %h", m0_rvalid, m0_rdata, ref_mem[5]);
        end
        step(); step();
    endtask

    task automatic test_random();
        logic [63:0] addr;
        logic [7:0]  wm;
        int          sel;
        for (int n = 0; n < 40; n++) begin
            addr = {55'd0, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 7) == 0) addr[$urandom_range(9, 63)] = 1'b1;
            sel = $urandom_range(0, 3);
            wm = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : 8'($urandom);
            do_op($urandom_range(0, 1), 1'($urandom_range(0, 1)), addr, {$urandom, $urandom}, wm);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 64'd0;
        last_rdata = 64'd0;
        test_reset();
        test_directed();
        test_round_robin();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
